// File: rtl/l1_refill_ctrl.sv
// l1_refill_ctrl: single-outstanding L1 miss handler; fetches a line byte-serially, writes it to the array, returns the requested byte
module l1_refill_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 3,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            miss_valid,
    input  logic [ADDR_W-1:0]               miss_addr,
    input  logic                            miss_way,
    output logic                            miss_ready,
    output logic                            mem_req,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic                            mem_gnt,
    input  logic                            mem_rvalid,
    input  logic [7:0]                      mem_rdata,
    output logic                            wr_en,
    output logic                            wr_way,
    output logic [INDEX_W-1:0]              wr_index,
    output logic [TAG_W+(8<<OFFSET_W):0]    wr_entry,
    output logic                            lru_upd,
    output logic                            resp_valid,
    output logic [7:0]                      resp_data,
    output logic                            busy
);
    localparam int LINE_W = 8 << OFFSET_W;

    typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, RESP} state_t;

    state_t              state, state_d;
    logic [OFFSET_W-1:0] cnt;
    logic [LINE_W-1:0]   line;
    logic [ADDR_W-1:0]   addr_q;
    logic                way_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            line   <= '0;
            addr_q <= '0;
            way_q  <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && miss_valid) begin
                addr_q <= miss_addr;
                way_q  <= miss_way;
                cnt    <= '0;
                line   <= '0;
            end
            if (state == FILL && mem_rvalid) begin
                line[8*cnt +: 8] <= mem_rdata;
                cnt              <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    state_d = miss_valid ? REQ : IDLE;
            REQ:     state_d = mem_gnt ? FILL : REQ;
            FILL:    state_d = (mem_rvalid && cnt == '1) ? WRITE : FILL;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign miss_ready = state == IDLE;
    assign busy       = state != IDLE;
    assign mem_req    = state == REQ;
    assign mem_addr   = mem_req ? {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}} : '0;
    assign wr_en      = state == WRITE;
    assign lru_upd    = wr_en;
    assign wr_way     = wr_en & way_q;
    assign wr_index   = wr_en ? addr_q[OFFSET_W +: INDEX_W] : '0;
    assign wr_entry   = wr_en ? {1'b1, addr_q[ADDR_W-1 -: TAG_W], line} : '0;
    assign resp_valid = state == RESP;
    assign resp_data  = resp_valid ? line[8*addr_q[OFFSET_W-1:0] +: 8] : '0;
endmodule

// File: tb/tb_l1_refill_ctrl.sv
// tb_l1_refill_ctrl: directed and randomized misses checked cycle-by-cycle against a line-level reference model
module tb_l1_refill_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        miss_valid = 1'b0, miss_way = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [15:0] miss_addr = '0;
    logic [7:0]  mem_rdata = '0;
    logic        miss_ready, mem_req, wr_en, wr_way, lru_upd, resp_valid, busy;
    logic [15:0] mem_addr;
    logic [5:0]  wr_index;
    logic [71:0] wr_entry;
    logic [7:0]  resp_data;
    int          checks = 0, failures = 0;
    logic [7:0]  line_b [8];

    l1_refill_ctrl dut (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_way(miss_way),
        .miss_ready(miss_ready), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wr_en(wr_en), .wr_way(wr_way),
        .wr_index(wr_index), .wr_entry(wr_entry), .lru_upd(lru_upd), .resp_valid(resp_valid),
        .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, miss_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_strobes"}, {mem_req, wr_en, lru_upd, resp_valid}, 4'b0);
    endtask

    task automatic fill_random;
        for (int k = 0; k < 8; k++) line_b[k] = 8'($urandom);
    endtask

    // Drives one complete miss starting in an IDLE cycle and ends positioned in the following IDLE cycle.
    task automatic run_miss(input logic [15:0] a, input logic w, input int gnt_dly, input int gap,
                            input bit spur, input bit hold, input logic [15:0] hold_addr);
        logic [63:0] exp_line;
        for (int k = 0; k < 8; k++) exp_line[8*k +: 8] = line_b[k];
        chk("accept_ready", miss_ready, 1'b1);
        miss_valid = 1'b1; miss_addr = a; miss_way = w;
        tick;
        miss_valid = hold; miss_addr = hold ? hold_addr : 16'h0; miss_way = 1'b0;
        for (int i = 0; i <= gnt_dly; i++) begin
            chk("req", mem_req, 1'b1);
            chk("req_addr", mem_addr, {a[15:3], 3'b000});
            chk("req_ready", miss_ready, 1'b0);
            chk("req_busy", busy, 1'b1);
            mem_gnt = (i == gnt_dly); mem_rvalid = spur; mem_rdata = 8'hFF;
            tick;
        end
        mem_gnt = spur;
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gap; g++) begin
                mem_rvalid = 1'b0;
                chk("fill_gap_req", mem_req, 1'b0);
                chk("fill_gap_strobes", {wr_en, resp_valid}, 2'b0);
                tick;
            end
            mem_rvalid = 1'b1; mem_rdata = line_b[k];
            chk("fill_busy", {busy, miss_ready, mem_req, wr_en, resp_valid}, 5'b10000);
            tick;
        end
        mem_rvalid = spur; mem_rdata = 8'hFF; mem_gnt = spur;
        chk("wr_en", {wr_en, lru_upd, resp_valid, mem_req}, 4'b1100);
        chk("wr_way", wr_way, w);
        chk("wr_index", wr_index, a[8:3]);
        chk("wr_entry", wr_entry, {1'b1, a[15:9], exp_line});
        tick;
        chk("resp_valid", {resp_valid, wr_en, lru_upd}, 3'b100);
        chk("resp_data", resp_data, line_b[a[2:0]]);
        chk("resp_entry_zero", wr_entry, 72'h0);
        tick;
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        chk_idle("post");
    endtask

    initial begin
        repeat (3) tick;
        chk_idle("in_reset");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk_idle("idle");
        end

        for (int k = 0; k < 8; k++) line_b[k] = 8'h10 + 8'(k);
        run_miss(16'h1A5D, 1'b1, 0, 0, 1'b0, 1'b0, 16'h0);
        run_miss(16'h1A5D, 1'b1, 3, 2, 1'b0, 1'b0, 16'h0);
        run_miss(16'h1A5D, 1'b1, 2, 1, 1'b1, 1'b1, 16'h0007);
        fill_random;
        run_miss(16'h0007, 1'b0, 0, 0, 1'b1, 1'b0, 16'h0);

        fill_random;
        miss_valid = 1'b1; miss_addr = 16'hBEEF; miss_way = 1'b1;
        tick;
        miss_valid = 1'b0; mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1; mem_rdata = line_b[k];
            tick;
        end
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = line_b[4];
        tick;
        reset = 1'b0;
        for (int k = 5; k < 8; k++) begin
            chk_idle("abort");
            mem_rvalid = 1'b1; mem_rdata = line_b[k];
            tick;
        end
        mem_rvalid = 1'b0;
        chk_idle("abort_end");
        fill_random;
        run_miss(16'h4321, 1'b0, 1, 0, 1'b0, 1'b0, 16'h0);

        for (int t = 0; t < 20; t++) begin
            fill_random;
            run_miss(16'($urandom), 1'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                     1'($urandom), 1'b0, 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
